regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug read-out engine for the processor's 32x32 register file. On a start pulse it walks the register file's read port from address 0 to NUM_REGS-1, captures each value and presents it on a valid/ready streaming output together with its address. It sits beside the register file, driving one of that file's combinational read-address ports. It replaces the single hard-wired register tap with a full register dump for on-board watermark and debug inspection.

## Interface
Parameters:
- NUM_REGS, 32: number of registers walked, addresses 0..NUM_REGS-1.
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a dump; sampled only in IDLE.
- busy  out  1  high in READ and SEND.
- done  out  1  one-cycle pulse after the last word is accepted.
- rd_addr  out  ADDR_W  to register file read address; registered.
- rd_data  in  DATA_W  from register file read data; combinational with rd_addr.
- out_valid  out  1  out_addr/out_data/out_last hold a word.
- out_ready  in  1  consumer accepts the word when high with out_valid.
- out_addr  out  ADDR_W  register index of the current word.
- out_data  out  DATA_W  captured register value.
- out_last  out  1  current word is index NUM_REGS-1.

## Operation
- States: IDLE, READ, SEND, DONE. Index counter idx is ADDR_W bits.
- IDLE: rd_addr=0, idx=0. If start=1 at an edge, go to READ.
- READ: rd_addr=idx. At the next edge, capture out_data<=rd_data and out_addr<=idx, set out_last=(idx==NUM_REGS-1), set out_valid=1, and go to SEND.
- SEND: hold out_* stable while out_ready=0. On an edge with out_valid&&out_ready:
  - Clear out_valid.
  - If idx==NUM_REGS-1, go to DONE.
  - Otherwise idx<=idx+1, rd_addr<=idx+1, and go to READ.
- DONE: done=1 for exactly one cycle, then IDLE. idx returns to 0; there is no wrap past NUM_REGS-1.
- start while busy or in DONE is ignored. It is not queued.
- Snapshot is per-word, not atomic. The register file writes on negedge clk, so a write to register k landing before the READ-exit edge for k is reflected in the dump.
- The dump is read-only and never drives the register file's rw/addr3/data3.
- rst asserted in any state, including mid-dump: immediately return to IDLE with all outputs at reset values. The next start restarts at address 0.

## Timing
- Reset values: busy=0, done=0, rd_addr=0, out_valid=0, out_addr=0, out_data=0, out_last=0, idx=0.
- start sampled at edge E0: READ during E0..E1, out_valid rises after E1.
- Each word takes 2 cycles minimum (READ + SEND). Each cycle out_ready=0 in SEND adds one cycle.
- With out_ready held 1: word i is accepted at edge E(2i+2), the last word at E64, done=1 during E64..E65, and the block is IDLE after E65.
- out_valid never drops without a handshake except on rst.

## Test plan
- Reset: assert rst mid-cycle asynchronously -> all outputs 0 immediately, without waiting for clk.
- Full dump, out_ready=1, register file at power-on contents: start pulse -> 32 words, out_addr 0..31 in order, out_data[9]=0x00000010, [10]=0x00000008, [11]=0x00000008, all others 0. out_last only on addr 31. done pulse at E64..E65, exactly one cycle. Total 64 cycles from start to done.
- Backpressure: out_ready=0 for 5 cycles while addr 9 is presented -> out_valid, out_addr=9 and out_data=0x00000010 held stable for all 5 cycles. Next word addr 10 appears 2 cycles after ready returns. Total dump is 5 cycles longer.
- Concurrent write: register file write of 0xDEADBEEF to reg 12 on the negedge before the READ-exit edge for idx 12 -> word 12 reads 0xDEADBEEF. The same write after word 12 is captured -> word 12 reads 0.
- Start during busy and DONE: extra start pulses at word 5 and during DONE are ignored -> exactly 32 words and one done pulse.
- Reset mid-dump at word 20 -> outputs zero immediately. A new start then yields addr 0 first and a full 32-word dump.

Source files
------------

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks the register file read port from address 0 to
// NUM_REGS-1 and streams each captured word with its address over valid/ready.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rd_addr_d   = rd_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                idx_d     = '0;
                rd_addr_d = '0;
                busy_d    = 1'b0;
                if (start) begin
                    state_d = READ;
                    busy_d  = 1'b1;
                end
            end
            READ: begin
                // rd_data is combinational on rd_addr, which already equals idx here
                out_data_d  = rd_data;
                out_addr_d  = idx_q;
                out_last_d  = (idx_q == LAST_IDX);
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d   = DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        idx_d     = '0;
                        rd_addr_d = '0;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        rd_addr_d = idx_q + 1'b1;
                        state_d   = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rd_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a behavioural 32x32 register file with
// negedge writes, a scenario table of dumps, and hand-written reset sequences.
module tb_regfile_dump;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] exp_words [NUM_REGS];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int stall_addr;
        int stall_len;
        int wr_idx;
        int wr_mode;      // 0 none, 1 before capture, 2 after capture
        bit extra_starts;
        int abort_addr;
        int exp_cycles;
    } scen_t;

    scen_t scens [7];

    regfile_dump #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_last (out_last)
    );

    assign rd_data = regs[rd_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},      32'(busy),      32'd0);
        checkOutput({tag, "_done"},      32'(done),      32'd0);
        checkOutput({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_addr"},  32'(out_addr),  32'd0);
        checkOutput({tag, "_out_data"},  out_data,       32'd0);
        checkOutput({tag, "_out_last"},  32'(out_last),  32'd0);
    endtask

    // Runs one dump; every loop pass starts 1 time unit after posedge E<cycle>.
    task automatic applyStimulus(input scen_t s);
        int                cycle      = 0;
        int                words      = 0;
        int                dones      = 0;
        int                done_cycle = -1;
        int                stall_left = s.stall_len;
        int                rr_cycle   = -1;
        bit                next_seen  = 1'b0;
        bit                wr_done    = 1'b0;
        bit                finished   = 1'b0;
        logic [ADDR_W-1:0] held_addr  = '0;
        logic [DATA_W-1:0] held_data  = '0;
        logic [DATA_W-1:0] exp_data;

        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);

        while (cycle < 300) begin
            start = 1'b0;

            if (s.abort_addr >= 0 && out_valid && int'(out_addr) == s.abort_addr) begin
                #2 rst = 1'b1;
                #1 checkResetOutputs("abort");
                @(negedge clk);
                rst = 1'b0;
                return;
            end

            if (done) begin
                dones++;
                if (dones == 1) begin
                    done_cycle = cycle;
                    checkOutput("done_cycle", 32'(cycle), 32'(s.exp_cycles));
                end
                if (s.extra_starts) start = 1'b1;
            end else if (done_cycle >= 0) begin
                checkOutput("idle_after_done", 32'(busy), 32'd0);
            end
            if (done_cycle >= 0 && cycle >= done_cycle + 4) begin
                finished = 1'b1;
                break;
            end

            if (rr_cycle >= 0 && !next_seen && out_valid &&
                int'(out_addr) == s.stall_addr + 1) begin
                next_seen = 1'b1;
                checkOutput("next_after_stall", 32'(cycle), 32'(rr_cycle + 2));
            end

            if (s.stall_addr >= 0 && out_valid && int'(out_addr) == s.stall_addr &&
                stall_left > 0) begin
                out_ready = 1'b0;
                if (stall_left == s.stall_len) begin
                    held_addr = out_addr;
                    held_data = out_data;
                end else begin
                    checkOutput("stall_valid", 32'(out_valid), 32'd1);
                    checkOutput("stall_addr", 32'(out_addr), 32'(held_addr));
                    checkOutput("stall_data", out_data, held_data);
                end
                stall_left--;
            end else begin
                out_ready = 1'b1;
                if (s.stall_addr >= 0 && s.stall_len > 0 && out_valid &&
                    int'(out_addr) == s.stall_addr && rr_cycle < 0)
                    rr_cycle = cycle;
            end

            if (s.extra_starts && out_valid && int'(out_addr) == 5) start = 1'b1;

            if (out_valid && out_ready) begin
                exp_data = exp_words[words];
                if (s.wr_mode == 1 && words == s.wr_idx) exp_data = 32'hDEADBEEF;
                checkOutput("word_addr", 32'(out_addr), 32'(words));
                checkOutput("word_data", out_data, exp_data);
                checkOutput("word_last", 32'(out_last), 32'(words == NUM_REGS - 1));
                words++;
            end

            if (s.wr_mode != 0 && !wr_done &&
                ((s.wr_mode == 1 && busy && !out_valid && int'(rd_addr) == s.wr_idx) ||
                 (s.wr_mode == 2 && out_valid && int'(out_addr) == s.wr_idx))) begin
                wr_done = 1'b1;
                @(negedge clk);
                regs[s.wr_idx] = 32'hDEADBEEF;
            end

            @(posedge clk); #1;
            cycle++;
        end

        if (!finished) checkOutput("dump_timeout", 32'(cycle), 32'(s.exp_cycles));
        checkOutput("word_count", 32'(words), 32'(NUM_REGS));
        checkOutput("done_count", 32'(dones), 32'd1);
        checkOutput("busy_end", 32'(busy), 32'd0);

        if (s.wr_mode != 0) begin
            @(negedge clk);
            regs[s.wr_idx] = '0;
        end
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;

        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i]      = '0;
            exp_words[i] = '0;
        end
        regs[9]  = 32'h00000010;
        regs[10] = 32'h00000008;
        regs[11] = 32'h00000008;
        exp_words[9]  = 32'h00000010;
        exp_words[10] = 32'h00000008;
        exp_words[11] = 32'h00000008;

        scens[0] = '{-1, 0, -1, 0, 1'b0, -1, 64};
        scens[1] = '{ 9, 5, -1, 0, 1'b0, -1, 69};
        scens[2] = '{-1, 0, 12, 1, 1'b0, -1, 64};
        scens[3] = '{-1, 0, 12, 2, 1'b0, -1, 64};
        scens[4] = '{-1, 0, -1, 0, 1'b1, -1, 64};
        scens[5] = '{-1, 0, -1, 0, 1'b0, 20, -1};
        scens[6] = '{-1, 0, -1, 0, 1'b0, -1, 64};

        // Asynchronous reset asserted between clock edges must act at once.
        #22 rst = 1'b1;
        #1 checkResetOutputs("por");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkResetOutputs("idle");

        for (int i = 0; i < 7; i++) begin
            $display("[TB] scenario %0d", i);
            applyStimulus(scens[i]);
            repeat (2) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
